imem_loader: RTL and testbench

Instruction-memory block that sits directly upstream of the single-cycle CPU core: it owns the instruction RAM, serves `instr` combinationally from the core's `PC`, and fills the RAM from a byte-wide host stream. While loading, it holds the core in reset. It releases the core once the final byte of the image has been written. A `reload` request re-enters load mode at any time after the core is running.

---
 rtl/imem_pkg.sv | 43 ++++
 rtl/imem_ram.sv | 39 +++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//                - state_e    : loader FSM states (LOAD / DONE / RUN)
//                - NOP_INSTR  : word returned for out-of-range fetches
//                - BYTE_CNT_W : width of the byte-within-word counter
//                - pack_word  : big-endian assembly of a (possibly partial)
//                               word from the shift register and new byte
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          BYTE_CNT_W = 2;

  // Build the word to write when byte number cnt (0..3) of a word arrives.
  // Earlier bytes of the word sit in the low end of the shift register, the
  // most recent in shift[7:0]. Missing trailing bytes are zero-padded, which
  // handles a partial final word in the same expression as a full one.
  function automatic logic [31:0] pack_word(
    input logic [23:0]           shift,
    input logic [BYTE_CNT_W-1:0] cnt,
    input logic [7:0]            new_byte
  );
    logic [31:0] word;
    case (cnt)
      2'd0:    word = {new_byte, 24'h00_0000};
      2'd1:    word = {shift[7:0], new_byte, 16'h0000};
      2'd2:    word = {shift[15:0], new_byte, 8'h00};
      default: word = {shift[23:0], new_byte};
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : 2^ADDR_WIDTH x 32-bit instruction RAM. One synchronous write
//                port and one asynchronous read port. No reset: contents
//                survive reset and reload.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write word address
//                wdata - write data
//                raddr - read word address
//                rdata - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction memory in front of a single-cycle core. Fills the
//                RAM from a byte-wide host stream (big-endian packing) while
//                holding the core in reset, then releases the core. A reload
//                request in RUN re-enters load mode.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                pc / instr      - core fetch address / instruction word
//                in_valid/in_data/in_last/in_ready - host byte stream
//                reload          - request a new load (honoured in RUN)
//                cpu_rst         - core reset (high unless RUN)
//                loaded          - high in RUN
//                words_loaded    - words written by the current/last load
//                overflow        - sticky: image exceeded RAM depth
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  output logic [31:0]           instr,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  cpu_rst,
  output logic                  loaded,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   WPTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(3);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e                state_q,    state_d;
  logic [ADDR_WIDTH:0]   wptr_q,     wptr_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q,    shift_d;
  logic                  overflow_q, overflow_d;
  logic                  cpu_rst_q,  cpu_rst_d;
  logic                  loaded_q,   loaded_d;
  logic                  in_ready_q, in_ready_d;

  logic                  accept;
  logic                  ram_full;
  logic                  word_done;
  logic                  ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  pc_in_range;
  logic                  unused_pc_lsbs;

  // wptr saturates at 2^ADDR_WIDTH, so its top bit alone marks a full RAM.
  assign ram_full  = wptr_q[ADDR_WIDTH];
  assign accept    = in_valid && in_ready_q;
  // A word is closed either by its fourth byte or by the image's last byte.
  assign word_done = accept && ((byte_cnt_q == CNT_LAST) || in_last);
  assign ram_we    = word_done && !ram_full;
  assign ram_wdata = pack_word(shift_q, byte_cnt_q, in_data);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          shift_d    = {shift_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + CNT_ONE;
          if (ram_full) begin
            overflow_d = 1'b1;
          end
          if (word_done) begin
            byte_cnt_d = '0;
            shift_d    = '0;
            if (!ram_full) begin
              wptr_d = wptr_q + WPTR_ONE;
            end
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = RUN;
      end
      RUN: begin
        if (reload) begin
          state_d    = LOAD;
          wptr_d     = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          overflow_d = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cpu_rst_d  = (state_d != RUN);
    loaded_d   = (state_d == RUN);
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      wptr_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      loaded_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      cpu_rst_q  <= cpu_rst_d;
      loaded_q   <= loaded_d;
      in_ready_q <= in_ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM and read path
  // --------------------------------------------------------------------------
  imem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (ram_wdata),
    .raddr (pc[ADDR_WIDTH+1:2]),
    .rdata (ram_rdata)
  );

  // Fetches above the RAM image read as a nop rather than aliasing.
  assign pc_in_range    = (pc[31:ADDR_WIDTH+2] == '0);
  assign unused_pc_lsbs = ^pc[1:0];

  assign instr        = pc_in_range ? ram_rdata : NOP_INSTR;
  assign in_ready     = in_ready_q;
  assign cpu_rst      = cpu_rst_q;
  assign loaded       = loaded_q;
  assign words_loaded = wptr_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Testbench for imem_loader. Two instances (ADDR_WIDTH 8 and 2)
//                share one stimulus stream; a byte-level image model predicts
//                RAM contents, word counts and overflow for each depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, reload;
  logic [7:0]  in_data;
  logic [31:0] pc;

  logic [31:0] instr_a, instr_b;
  logic        in_ready_a, in_ready_b, cpu_rst_a, cpu_rst_b;
  logic        loaded_a, loaded_b, ov_a, ov_b;
  logic [8:0]  wl_a;
  logic [2:0]  wl_b;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr_a),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_a), .reload(reload), .cpu_rst(cpu_rst_a),
    .loaded(loaded_a), .words_loaded(wl_a), .overflow(ov_a)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr_b),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_b), .reload(reload), .cpu_rst(cpu_rst_b),
    .loaded(loaded_b), .words_loaded(wl_b), .overflow(ov_b)
  );

  int tests_run = 0;
  int failed    = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: index 0 is the 256-word instance, index 1 the 4-word one
  // --------------------------------------------------------------------------
  logic [31:0] mm [2][256];
  bit          kn [2][256];
  logic [7:0]  img [$];

  function automatic int aw_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  task automatic model_apply(input int n, input bit complete);
    for (int d = 0; d < 2; d++) begin
      int depth;
      int nw;
      depth = 1 << aw_of(d);
      nw    = complete ? (n + 3) / 4 : n / 4;
      for (int w = 0; w < nw && w < depth; w++) begin
        logic [31:0] word;
        word = 32'h0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx  = 4 * w + k;
          word = {word[23:0], (idx < n) ? img[idx] : 8'h00};
        end
        mm[d][w] = word;
        kn[d][w] = 1'b1;
      end
    end
  endtask

  task automatic exp_rd(input int d, input logic [31:0] p, output logic [31:0] e, output bit k);
    int a;
    int idx;
    a = aw_of(d);
    if ((p >> (a + 2)) != 0) begin
      e = 32'h0;
      k = 1'b1;
    end else begin
      idx = int'((p >> 2) & ((32'd1 << a) - 1));
      e   = mm[d][idx];
      k   = kn[d][idx];
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard queues and monitor
  // --------------------------------------------------------------------------
  typedef struct {
    bit          is_ctrl;
    logic [31:0] ea, eb;
    bit          ka, kb;
  } chk_t;

  typedef struct {
    logic [8:0] wla;
    logic [2:0] wlb;
    bit         ova, ovb;
  } ld_t;

  chk_t chk_q [$];
  ld_t  ld_q  [$];
  bit   stb = 1'b0;

  int ncnt    = 0;
  int last_hs = -100;
  bit prev_loaded = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      ncnt++;
      if (stb) begin
        if (chk_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL chk_queue: got empty expected an item");
        end else begin
          chk_t c;
          c = chk_q.pop_front();
          if (c.is_ctrl) begin
            cmp("cpu_rst_a",  {31'b0, cpu_rst_a},  32'd1);
            cmp("loaded_a",   {31'b0, loaded_a},   32'd0);
            cmp("in_ready_a", {31'b0, in_ready_a}, 32'd1);
            cmp("wl_a_clear", {23'b0, wl_a},       32'd0);
            cmp("ov_a_clear", {31'b0, ov_a},       32'd0);
            cmp("cpu_rst_b",  {31'b0, cpu_rst_b},  32'd1);
            cmp("wl_b_clear", {29'b0, wl_b},       32'd0);
          end else begin
            if (c.ka) cmp("instr_a", instr_a, c.ea);
            if (c.kb) cmp("instr_b", instr_b, c.eb);
          end
        end
      end
      if (loaded_a && !prev_loaded) begin
        if (ld_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL unexpected_run: got loaded=1 expected no load pending");
        end else begin
          ld_t l;
          l = ld_q.pop_front();
          cmp("words_loaded_a", {23'b0, wl_a}, {23'b0, l.wla});
          cmp("overflow_a",     {31'b0, ov_a}, {31'b0, l.ova});
          cmp("words_loaded_b", {29'b0, wl_b}, {29'b0, l.wlb});
          cmp("overflow_b",     {31'b0, ov_b}, {31'b0, l.ovb});
          cmp("loaded_b",       {31'b0, loaded_b}, 32'd1);
          cmp("release_latency", 32'(ncnt - last_hs), 32'd1);
        end
      end
      prev_loaded = loaded_a;
      if (in_valid && in_ready_a && in_last && !rst) last_hs = ncnt + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus tasks (all entered at #1 after a rising edge)
  // --------------------------------------------------------------------------
  task automatic check_ctrl();
    chk_t c;
    c.is_ctrl = 1'b1; c.ea = '0; c.eb = '0; c.ka = 1'b0; c.kb = 1'b0;
    chk_q.push_back(c);
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_ctrl();
  endtask

  task automatic do_reload();
    in_valid = 1'b0; in_last = 1'b0; reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check_ctrl();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 10 && !loaded_a; i++) begin
      @(posedge clk); #1;
    end
    cmp("run_reached", {31'b0, loaded_a}, 32'd1);
  endtask

  // abort_at < 0 sends the whole image with in_last; otherwise stops after
  // abort_at bytes without in_last. reload toggles randomly and must be ignored.
  task automatic send_image(input int abort_at);
    int n;
    int lim;
    n   = img.size();
    lim = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < lim; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        reload = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = img[i];
      in_last  = (abort_at < 0) && (i == n - 1);
      reload   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    if (abort_at < 0) begin
      ld_t l;
      l.wla = 9'((((n + 3) / 4) > 256) ? 256 : (n + 3) / 4);
      l.wlb = 3'((((n + 3) / 4) > 4) ? 4 : (n + 3) / 4);
      l.ova = (n > 1024);
      l.ovb = (n > 16);
      ld_q.push_back(l);
      model_apply(n, 1'b1);
      wait_run();
    end else begin
      model_apply(abort_at, 1'b0);
    end
  endtask

  task automatic do_read(input logic [31:0] p);
    chk_t c;
    c.is_ctrl = 1'b0;
    exp_rd(0, p, c.ea, c.ka);
    exp_rd(1, p, c.eb, c.kb);
    if (c.ka || c.kb) begin
      pc = p;
      // Stream noise while not in LOAD must be ignored.
      in_valid = 1'($urandom); in_data = 8'($urandom); in_last = 1'($urandom);
      chk_q.push_back(c);
      stb = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic readback(input int n);
    int nw;
    nw = (n + 3) / 4;
    for (int w = 0; w <= nw && w < 64; w++) begin
      do_read(32'(4 * w + $urandom_range(0, 3)));
    end
    do_read($urandom);
    do_read(32'($urandom_range(0, 1023)));
    do_read(32'h0000_0400);
  endtask

  task automatic set_random_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1; pc = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0;
    do_reset();

    // Two full words
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_image(-1);
    readback(8);
    do_read(32'h4);
    do_read(32'h7);

    // Partial final word
    do_reload();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_image(-1);
    readback(5);

    // 20 bytes: overflows the 4-word instance only
    do_reload();
    set_random_image(20);
    send_image(-1);
    readback(20);

    // Short image leaves word 1 stale
    do_reload();
    img = '{8'h00, 8'h00, 8'h00, 8'h0C};
    send_image(-1);
    readback(4);

    // Reset after six bytes, then a fresh load
    do_reload();
    set_random_image(12);
    send_image(6);
    do_reset();
    set_random_image(9);
    send_image(-1);
    readback(9);

    // Random images, some interrupted by reset
    for (int it = 0; it < 10; it++) begin
      int n;
      do_reload();
      n = $urandom_range(1, 40);
      set_random_image(n);
      if ($urandom_range(0, 3) == 0) begin
        send_image($urandom_range(0, n - 1));
        do_reset();
        n = $urandom_range(1, 40);
        set_random_image(n);
      end
      send_image(-1);
      readback(n);
    end

    repeat (3) @(posedge clk);
    tests_run++;
    if (chk_q.size() != 0 || ld_q.size() != 0) begin
      failed++;
      $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", chk_q.size(), ld_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
